noise_sh_slew: RTL and testbench

- Sample-and-hold with slew limiting. Turns the 18-bit filtered noise stream into a stepped or gliding random modulation voltage.
- Sits directly downstream of the 64-bit LFSR noise generator and its IIR low-pass output.
- Runs on the same sample-rate enable strobe.
- New samples are triggered by an external gate edge (GateMan) and/or an internal ena-tick divider.

---
 rtl/noise_pkg.sv | 13 +
 rtl/noise_sh_slew_if.sv | 26 ++
 rtl/gate_edge_sync.sv | 48 ++++
 rtl/noise_sh_slew.sv | 117 +++++++++++
 tb/tb_noise_sh_slew.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/noise_pkg.sv
// Shared constants and slew FSM state encoding for the noise sample-and-hold block.
package noise_pkg;

    localparam int unsigned DSZ_DEF  = 18;
    localparam int unsigned DIVW_DEF = 16;
    localparam int unsigned SLEW_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SLEW = 1'b1
    } slew_state_e;

endpackage

// File: rtl/noise_sh_slew_if.sv
// Sample-rate, trigger and held-output signals between the noise source side and noise_sh_slew.
interface noise_sh_slew_if #(
    parameter int unsigned DSZ  = noise_pkg::DSZ_DEF,
    parameter int unsigned DIVW = noise_pkg::DIVW_DEF
);

    logic                           ena;
    logic [DSZ-1:0]                 in;
    logic                           trig_in;
    logic [DIVW-1:0]                rate_div;
    logic [noise_pkg::SLEW_W-1:0]   slew;
    logic [DSZ-1:0]                 out;
    logic                           step_strobe;
    logic                           busy;

    modport master (
        output ena, in, trig_in, rate_div, slew,
        input  out, step_strobe, busy
    );

    modport slave (
        input  ena, in, trig_in, rate_div, slew,
        output out, step_strobe, busy
    );

endinterface

// File: rtl/gate_edge_sync.sv
// Synchronises the gate, arms only after the gate has been seen low, and emits a
// one-clk pulse on each armed rising edge.
module gate_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic trig_in,
    output logic ext_edge
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       sync3_q, sync3_d;
    logic [1:0] fill_q,  fill_d;
    logic       armed_q, armed_d;
    logic       edge_q,  edge_d;

    // fill tracks when sync2 holds a genuinely sampled value, so a gate held
    // high across reset is not mistaken for a low-then-high transition.
    always_comb begin
        sync1_d = trig_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
        edge_d  = armed_q & sync2_q & ~sync3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            edge_q  <= edge_d;
        end
    end

    assign ext_edge = edge_q;

endmodule

// File: rtl/noise_sh_slew.sv
// Sample-and-hold with slew limiting: captures filtered noise on gate/divider
// triggers and glides the held output toward each new target on ena ticks.
module noise_sh_slew
    import noise_pkg::*;
#(
    parameter int unsigned DSZ  = DSZ_DEF,
    parameter int unsigned DIVW = DIVW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    noise_sh_slew_if.slave bus
);

    localparam int unsigned WX = DSZ + 1;

    slew_state_e     state_q, state_d;
    logic [DSZ-1:0]  out_q, out_d;
    logic [DSZ-1:0]  target_q, target_d;
    logic [DIVW-1:0] divcnt_q, divcnt_d;
    logic            pending_q, pending_d;
    logic            step_strobe_q, step_strobe_d;
    logic            busy_q, busy_d;

    logic            ext_edge;
    logic            div_fire;
    logic            capture;
    logic signed [WX-1:0] diff;
    logic signed [WX-1:0] step;
    logic signed [WX-1:0] sum;
    logic [DSZ-1:0]  slewed;

    gate_edge_sync u_gate_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .trig_in  (bus.trig_in),
        .ext_edge (ext_edge)
    );

    // Slew step toward the pre-capture target; |step| <= |diff| so no overflow.
    always_comb begin
        diff = $signed({target_q[DSZ-1], target_q}) - $signed({out_q[DSZ-1], out_q});
        step = diff >>> bus.slew;
        if ((step == '0) && (diff != '0)) begin
            step = diff[DSZ] ? '1 : WX'(1);
        end
        sum    = $signed({out_q[DSZ-1], out_q}) + step;
        slewed = (bus.slew == '0) ? target_q : sum[DSZ-1:0];
    end

    always_comb begin
        divcnt_d      = divcnt_q;
        div_fire      = 1'b0;
        state_d       = state_q;
        out_d         = out_q;

        if (bus.ena) begin
            if (bus.rate_div == '0) begin
                divcnt_d = '0;
            end else if (divcnt_q == '0) begin
                divcnt_d = bus.rate_div - DIVW'(1);
                div_fire = 1'b1;
            end else begin
                divcnt_d = divcnt_q - DIVW'(1);
            end
        end

        // Triggers arriving between enas merge into a single capture.
        capture       = bus.ena & (pending_q | ext_edge | div_fire);
        pending_d     = capture ? 1'b0 : (pending_q | ext_edge);
        target_d      = capture ? bus.in : target_q;
        step_strobe_d = capture;

        case (state_q)
            IDLE: begin
                if (capture && (bus.in != out_q)) begin
                    state_d = SLEW;
                end
            end
            SLEW: begin
                if (bus.ena) begin
                    out_d = slewed;
                    if (!capture && (slewed == target_q)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SLEW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            out_q         <= '0;
            target_q      <= '0;
            divcnt_q      <= '0;
            pending_q     <= 1'b0;
            step_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_q         <= out_d;
            target_q      <= target_d;
            divcnt_q      <= divcnt_d;
            pending_q     <= pending_d;
            step_strobe_q <= step_strobe_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.step_strobe = step_strobe_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_noise_sh_slew.sv
// Self-checking bench for noise_sh_slew: vector table plus hand-written corner sequences.
module tb_noise_sh_slew;
    import noise_pkg::*;

    localparam int unsigned DW = DSZ_DEF;

    typedef struct {
        logic          trig;
        logic [DW-1:0] din;
        logic [4:0]    slew;
        logic [DW-1:0] eo;
        logic          eb;
        logic          es;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] out;
        logic          busy;
        logic          strobe;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noise_sh_slew_if bus ();

    noise_sh_slew dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk    = 0;
    int   n_err    = 0;
    int   n_strobe = 0;
    vec_t vecs[$];
    exp_t sb_q[$];
    int   glide [25] = '{250, 437, 577, 682, 761, 820, 865, 898, 923, 942, 956, 967, 975,
                         981, 985, 988, 991, 993, 994, 995, 996, 997, 998, 999, 1000};

    always @(negedge clk) begin
        if (bus.step_strobe === 1'b1) n_strobe++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // One ena pulse; expectation queued at drive time, popped once outputs settle.
    task automatic ena_check(input string nm, input logic [DW-1:0] eo, input logic eb, input logic es);
        exp_t e;
        sb_q.push_back('{eo, eb, es});
        @(posedge clk); #1 bus.ena = 1'b1;
        @(posedge clk); #1 bus.ena = 1'b0;
        e = sb_q.pop_front();
        chk({nm, ".out"},    32'(bus.out),         32'(e.out));
        chk({nm, ".busy"},   32'(bus.busy),        32'(e.busy));
        chk({nm, ".strobe"}, 32'(bus.step_strobe), 32'(e.strobe));
    endtask

    task automatic trig_pulse();
        bus.trig_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.trig_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int s0;
        logic [DW-1:0] exp_o;
        logic fire;

        rst = 1'b1;
        bus.ena = 1'b0; bus.in = '0; bus.trig_in = 1'b0; bus.rate_div = '0; bus.slew = '0;

        // Step with slew=0, return to 0, glide with slew=2, then an equal-value capture
        vecs.push_back('{1'b1, 18'h0A000, 5'd0, 18'h00000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 18'h0A000, 5'd0, 18'h0A000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 18'h00000, 5'd0, 18'h0A000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 18'h00000, 5'd0, 18'h00000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 18'd1000,  5'd2, 18'h00000, 1'b1, 1'b1});
        for (int k = 0; k < 25; k++)
            vecs.push_back('{1'b0, 18'd1000, 5'd2, 18'(glide[k]), (k != 24), 1'b0});
        vecs.push_back('{1'b1, 18'd1000,  5'd2, 18'd1000, 1'b0, 1'b1});

        do_reset();
        chk("reset.out",    32'(bus.out), 0);
        chk("reset.busy",   32'(bus.busy), 0);
        chk("reset.strobe", 32'(bus.step_strobe), 0);

        // Idle: no triggers, no divider
        s0 = n_strobe;
        for (int i = 0; i < 100; i++) begin
            repeat (14) @(posedge clk);
            ena_check($sformatf("idle%0d", i), '0, 1'b0, 1'b0);
        end
        chk("idle.strobes", 32'(n_strobe - s0), 0);

        foreach (vecs[i]) begin
            bus.in   = vecs[i].din;
            bus.slew = vecs[i].slew;
            if (vecs[i].trig) trig_pulse();
            ena_check($sformatf("vec%0d", i), vecs[i].eo, vecs[i].eb, vecs[i].es);
        end

        // Internal divider: period 4, switched to 2 mid-count (effective at next reload)
        bus.slew = 5'd0;
        bus.rate_div = 16'd4;
        exp_o = 18'd1000;
        for (int e = 0; e <= 20; e++) begin
            if (e == 14) bus.rate_div = 16'd2;
            bus.in = 18'(100 + e);
            fire = (e == 0) || (e == 4) || (e == 8) || (e == 12) ||
                   (e == 16) || (e == 18) || (e == 20);
            ena_check($sformatf("div%0d", e), exp_o, fire, fire);
            if (fire) exp_o = 18'(100 + e);
        end
        bus.rate_div = '0;
        ena_check("div_off", 18'd120, 1'b0, 1'b0);

        // Gate held high across reset release must not trigger
        bus.trig_in = 1'b1;
        repeat (3) @(posedge clk);
        do_reset();
        repeat (10) @(posedge clk);
        bus.in = 18'd5;
        ena_check("held_gate", '0, 1'b0, 1'b0);
        #1 bus.trig_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 trig_pulse();
        ena_check("rearm_cap", '0, 1'b1, 1'b1);
        ena_check("rearm_out", 18'd5, 1'b0, 1'b0);

        // Two gate rises between enas merge into one capture
        bus.in = 18'd9;
        trig_pulse();
        trig_pulse();
        s0 = n_strobe;
        ena_check("dbl_cap", 18'd5, 1'b1, 1'b1);
        ena_check("dbl_out", 18'd9, 1'b0, 1'b0);
        chk("dbl.strobes", 32'(n_strobe - s0), 1);

        // Retarget during SLEW: step uses old target, new target from the next ena
        bus.slew = 5'd2;
        bus.in = 18'd1009;
        trig_pulse();
        ena_check("rt_cap1", 18'd9, 1'b1, 1'b1);
        ena_check("rt_s1",   18'd259, 1'b1, 1'b0);
        bus.in = 18'd9;
        trig_pulse();
        ena_check("rt_cap2", 18'd446, 1'b1, 1'b1);
        ena_check("rt_s2",   18'd336, 1'b1, 1'b0);
        bus.slew = 5'd0;
        ena_check("rt_snap", 18'd9, 1'b0, 1'b0);

        // Extremes: most negative to most positive at slew=31
        bus.in = 18'h20000;
        trig_pulse();
        ena_check("ext_cap0", 18'd9, 1'b1, 1'b1);
        ena_check("ext_min",  18'h20000, 1'b0, 1'b0);
        bus.slew = 5'd31;
        bus.in = 18'h1FFFF;
        trig_pulse();
        ena_check("ext_cap1", 18'h20000, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++)
            ena_check($sformatf("ext_s%0d", k), 18'(18'h20000 + k), 1'b1, 1'b0);

        // Asynchronous reset mid-glide, checked before any clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.out",  32'(bus.out), 0);
        chk("async_rst.busy", 32'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ena_check("post_rst", '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
